// File: rtl/reg_dump_pkg.sv
// Shared definitions for the register read-out transmitter: FSM encoding and line levels.
package reg_dump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam logic TX_IDLE = 1'b1;

endpackage

// File: rtl/baud_tick.sv
// Bit-period timer: counts CLKS_PER_BIT cycles while enabled and flags the last cycle of each bit.
module baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = en && !clear && (cnt == LAST_CNT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/reg_dump_tx.sv
// UART-style serial dump of an N-bit word: start bit, LSB-first data, optional even parity, stop bit.
// Define REG_DUMP_TX_PARITY_EN to insert the even-parity bit between data and stop.
module reg_dump_tx
    import reg_dump_pkg::*;
#(
    parameter int N            = 32,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] din,
    output logic         ready,
    output logic         done,
    output logic         tx
);

    localparam int BIT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(N - 1);

    state_t           state;
    state_t           state_next;
    logic [N-1:0]     shreg;
    logic [BIT_W-1:0] bit_cnt;
    logic             tick;
    logic             accept;
    logic             last_bit;
    logic             busy;
    logic             tx_next;
    logic             ready_next;
    logic             done_next;
`ifdef REG_DUMP_TX_PARITY_EN
    logic             parity;
`endif

    assign accept   = (state == ST_IDLE) && start;
    assign last_bit = (bit_cnt == LAST_BIT);
    assign busy     = (state != ST_IDLE);

    baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk  (clk),
        .rst  (rst),
        .clear(accept),
        .en   (busy),
        .tick (tick)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every comb output gets a default before the case so no latch can be inferred.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start) state_next = ST_START;
            ST_START:  if (tick) state_next = ST_DATA;
            ST_DATA: begin
                if (tick && last_bit) begin
`ifdef REG_DUMP_TX_PARITY_EN
                    state_next = ST_PARITY;
`else
                    state_next = ST_STOP;
`endif
                end
            end
`ifdef REG_DUMP_TX_PARITY_EN
            ST_PARITY: if (tick) state_next = ST_STOP;
`endif
            ST_STOP:   if (tick) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // The word is frozen at acceptance; later din changes never reach the line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (accept) begin
            shreg   <= din;
            bit_cnt <= '0;
        end else if ((state == ST_DATA) && tick) begin
            shreg   <= shreg >> 1;
            bit_cnt <= last_bit ? '0 : bit_cnt + BIT_W'(1);
        end
    end

`ifdef REG_DUMP_TX_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity <= 1'b0;
        end else if (accept) begin
            parity <= ^din;
        end
    end
`endif

    always_comb begin
        tx_next    = TX_IDLE;
        ready_next = 1'b0;
        done_next  = 1'b0;
        case (state)
            ST_IDLE: begin
                tx_next    = TX_IDLE;
                ready_next = 1'b1;
            end
            ST_START:  tx_next = ~TX_IDLE;
            ST_DATA:   tx_next = shreg[0];
`ifdef REG_DUMP_TX_PARITY_EN
            ST_PARITY: tx_next = parity;
`endif
            ST_STOP: begin
                tx_next   = TX_IDLE;
                done_next = tick;
            end
            default:   tx_next = TX_IDLE;
        endcase
    end

    // Outputs are registered one cycle behind the state, so the line lags acceptance by a cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx    <= TX_IDLE;
            ready <= 1'b1;
            done  <= 1'b0;
        end else begin
            tx    <= tx_next;
            ready <= ready_next;
            done  <= done_next;
        end
    end

endmodule

// File: tb/tb_reg_dump_tx.sv
// Randomised self-checking bench for reg_dump_tx against a frame-level timing model.
module tb_reg_dump_tx;

    localparam int N = 8;
    localparam int C = 4;
`ifdef REG_DUMP_TX_PARITY_EN
    localparam int SLOTS = N + 3;
    localparam bit PAR   = 1'b1;
    localparam int LIT_F = 44;
    localparam logic [10:0] LIT_A5 = 11'b10101001010;
`else
    localparam int SLOTS = N + 2;
    localparam bit PAR   = 1'b0;
    localparam int LIT_F = 40;
    localparam logic [10:0] LIT_A5 = 11'b01101001010;
`endif
    localparam int F = SLOTS * C;

    logic         clk   = 1'b0;
    logic         rst   = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] din   = '0;
    logic         ready;
    logic         done;
    logic         tx;

    reg_dump_tx #(
        .N           (N),
        .CLKS_PER_BIT(C)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .din  (din),
        .ready(ready),
        .done (done),
        .tx   (tx)
    );

    always #5 clk = ~clk;

    int           passed   = 0;
    int           total    = 0;
    int           cyc      = 0;
    bit           m_active = 1'b0;
    int           m_a      = 0;
    logic [N-1:0] m_d      = '0;
    bit           cmp_en   = 1'b0;
    int           done_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    endtask

    // Line level of frame slot j for word d: start, data LSB first, optional parity, stop.
    function automatic logic slot_bit(input logic [N-1:0] d, input int j);
        if (j == 0) return 1'b0;
        if (j <= N) return d[j-1];
        if (PAR && j == N + 1) return ^d;
        return 1'b1;
    endfunction

    // Model: a word is accepted at edge k if start is high and the previous frame ended before k.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst) begin
            m_active = 1'b0;
        end else if (start && (!m_active || cyc > m_a + F)) begin
            m_active = 1'b1;
            m_a      = cyc;
            m_d      = din;
        end
    end

    always @(negedge clk) begin
        int   t;
        logic etx;
        logic erdy;
        logic edone;
        if (cmp_en && rst) begin
            t     = m_active ? cyc - m_a : 0;
            etx   = 1'b1;
            erdy  = 1'b1;
            edone = 1'b0;
            if (m_active && t >= 1 && t <= F) begin
                etx   = slot_bit(m_d, (t - 1) / C);
                erdy  = 1'b0;
                edone = (t == F);
            end
            check("cyc_tx", 32'(tx), 32'(etx));
            check("cyc_ready", 32'(ready), 32'(erdy));
            check("cyc_done", 32'(done), 32'(edone));
        end
    end

    always @(negedge clk) begin
        if (rst && done === 1'b1) done_q.push_back(cyc);
    end

    task automatic wait_cycle(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    task automatic pulse_start(input logic [N-1:0] d, output int acc);
        @(posedge clk);
        #1;
        start = 1'b1;
        din   = d;
        @(posedge clk);
        #1;
        acc   = cyc;
        start = 1'b0;
        din   = N'($urandom);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int           a;
        logic [N-1:0] d;

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst    = 1'b1;
        cmp_en = 1'b1;
        repeat (3) @(negedge clk);

        // Reset asserted while done is high: all outputs return to idle without a clock edge.
        pulse_start(8'h5A, a);
        wait_cycle(a + F);
        #2;
        rst = 1'b0;
        #1;
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_ready", 32'(ready), 32'd1);
        check("reset_done", 32'(done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        done_q.delete();

        // Single 0xA5 frame against hand-derived mid-bit samples.
        pulse_start(8'hA5, a);
        for (int j = 0; j < SLOTS; j++) begin
            wait_cycle(a + 1 + C * j + C / 2);
            check("a5_slot", 32'(tx), 32'(LIT_A5[j]));
        end
        wait_cycle(a + F);
        check("a5_ready_busy", 32'(ready), 32'd0);
        wait_cycle(a + F + 1);
        check("a5_ready_back", 32'(ready), 32'd1);
        wait_cycle(a + F + 2);
        check("a5_done_count", 32'(done_q.size()), 32'd1);
        check("a5_done_cycle", 32'(done_q[0] - a), 32'(LIT_F));
        done_q.delete();

`ifdef REG_DUMP_TX_PARITY_EN
        pulse_start(8'h07, a);
        wait_cycle(a + 1 + C * (N + 1) + C / 2);
        check("p07_parity", 32'(tx), 32'd1);
        wait_cycle(a + F + 2);
        done_q.delete();
`endif

        // Start while busy is dropped.
        pulse_start(8'h00, a);
        wait_cycle(a + 10);
        start = 1'b1;
        din   = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        wait_cycle(a + F + 3);
        check("busy_done_count", 32'(done_q.size()), 32'd1);
        check("busy_done_cycle", 32'(done_q[0] - a), 32'(F));
        done_q.delete();

        // Back-to-back with start held: the next accept happens on the first idle edge.
        @(posedge clk);
        #1;
        start = 1'b1;
        din   = 8'h3C;
        @(posedge clk);
        #1;
        a   = cyc;
        din = 8'hC3;
        wait_cycle(a + F + 1);
        start = 1'b0;
        check("b2b_gap_tx", 32'(tx), 32'd1);
        check("b2b_gap_ready", 32'(ready), 32'd1);
        wait_cycle(a + F + 2);
        check("b2b_second_start", 32'(tx), 32'd0);
        wait_cycle(a + 2 * F + 3);
        check("b2b_done_count", 32'(done_q.size()), 32'd2);
        check("b2b_first_done", 32'(done_q[0] - a), 32'(F));
        check("b2b_done_spacing", 32'(done_q[1] - done_q[0]), 32'(F + 1));
        done_q.delete();

        // Reset during data bit 3 abandons the frame.
        pulse_start(8'hF0, a);
        wait_cycle(a + 1 + C * 4 + 1);
        check("midrst_pre_tx", 32'(tx), 32'd0);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_tx", 32'(tx), 32'd1);
        check("midrst_ready", 32'(ready), 32'd1);
        check("midrst_done", 32'(done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        wait_cycle(a + F + 8);
        check("midrst_no_done", 32'(done_q.size()), 32'd0);
        pulse_start(8'h01, a);
        wait_cycle(a + F + 2);
        check("post_rst_done_count", 32'(done_q.size()), 32'd1);
        check("post_rst_done_cycle", 32'(done_q[0] - a), 32'(F));
        done_q.delete();

        // Random words, random gaps and random ignored starts.
        for (int i = 0; i < 20; i++) begin
            d = N'($urandom);
            pulse_start(d, a);
            if ($urandom_range(0, 1) == 1) begin
                wait_cycle(a + int'($urandom_range(2, F - 2)));
                start = 1'b1;
                din   = N'($urandom);
                @(negedge clk);
                start = 1'b0;
            end
            wait_cycle(a + F + 1 + int'($urandom_range(0, 3)));
            check("rand_done_count", 32'(done_q.size()), 32'd1);
            done_q.delete();
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
